// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter feeding one shared two-stage registered adder; results
// come back tagged with the index of the requester that issued them.
module adder_share_arbiter #(
  parameter int WIDTH   = 5,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst_a,
  input  logic                     enable,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] op_a,
  input  logic [NUM_REQ*WIDTH-1:0] op_b,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     sum_valid,
  output logic [WIDTH-1:0]         sum_data,
  output logic                     sum_carry,
  output logic [ID_W-1:0]          sum_id,
  input  logic                     sum_ready,
  output logic                     busy
);

  logic [ID_W-1:0]  ptr;
  logic             advance;
  logic             grant_any;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W-1:0]  ptr_next;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  logic             vld_p1;
  logic [WIDTH-1:0] a_p1;
  logic [WIDTH-1:0] b_p1;
  logic [ID_W-1:0]  id_p1;

  function automatic int scan_idx(input logic [ID_W-1:0] p, input int off);
    int i;
    i = int'(p) + off;
    if (i >= NUM_REQ) i -= NUM_REQ;
    return i;
  endfunction

  function automatic logic [WIDTH:0] add_carry(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  assign advance = enable & ~(sum_valid & ~sum_ready);
  assign busy    = vld_p1 | sum_valid;

  // Arbitration: first asserted request at or after ptr, wrapping at NUM_REQ-1
  always_comb begin
    gnt       = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    if (rst_a && advance) begin
      for (int off = 0; off < NUM_REQ; off++) begin
        if (!grant_any && req[scan_idx(ptr, off)]) begin
          grant_any                  = 1'b1;
          grant_idx                  = ID_W'(scan_idx(ptr, off));
          gnt[scan_idx(ptr, off)]    = 1'b1;
        end
      end
    end
  end

  assign ptr_next = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
  assign sel_a    = op_a[int'(grant_idx)*WIDTH +: WIDTH];
  assign sel_b    = op_b[int'(grant_idx)*WIDTH +: WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_a) begin
      ptr       <= '0;
      vld_p1    <= 1'b0;
      a_p1      <= '0;
      b_p1      <= '0;
      id_p1     <= '0;
      sum_valid <= 1'b0;
      sum_data  <= '0;
      sum_carry <= 1'b0;
      sum_id    <= '0;
    end else if (advance) begin
      // Stage 1: capture the granted operand pair
      vld_p1 <= grant_any;
      if (grant_any) begin
        a_p1  <= sel_a;
        b_p1  <= sel_b;
        id_p1 <= grant_idx;
        ptr   <= ptr_next;
      end
      // Output stage: register the sum; data holds across bubbles
      sum_valid <= vld_p1;
      if (vld_p1) begin
        {sum_carry, sum_data} <= add_carry(a_p1, b_p1);
        sum_id                <= id_p1;
      end
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Randomized bench for adder_share_arbiter, checked cycle by cycle against a
// transaction-level model of the round-robin arbiter and two-slot pipeline.
module tb_adder_share_arbiter;
  localparam int WIDTH   = 5;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                     clk;
  logic                     rst_a;
  logic                     enable;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] op_a;
  logic [NUM_REQ*WIDTH-1:0] op_b;
  logic [NUM_REQ-1:0]       gnt;
  logic                     sum_valid;
  logic [WIDTH-1:0]         sum_data;
  logic                     sum_carry;
  logic [ID_W-1:0]          sum_id;
  logic                     sum_ready;
  logic                     busy;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: next-priority index plus the two pipeline slots
  int m_ptr;
  int m_s1_v, m_s1_a, m_s1_b, m_s1_id;
  int m_out_v, m_out_data, m_out_carry, m_out_id;

  adder_share_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst_a(rst_a), .enable(enable), .req(req),
    .op_a(op_a), .op_b(op_b), .gnt(gnt), .sum_valid(sum_valid),
    .sum_data(sum_data), .sum_carry(sum_carry), .sum_id(sum_id),
    .sum_ready(sum_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_ops(input int idx, input int a, input int b);
    op_a[idx*WIDTH +: WIDTH] = WIDTH'(a);
    op_b[idx*WIDTH +: WIDTH] = WIDTH'(b);
  endtask

  // Check one cycle at mid-period, advance the model, then cross the edge.
  task automatic step();
    int adv, k, total, exp_gnt;
    #4;
    adv = (enable && !(m_out_v && !sum_ready)) ? 1 : 0;
    k = -1;
    if (rst_a && adv) begin
      for (int off = 0; off < NUM_REQ; off++) begin
        if (req[(m_ptr + off) % NUM_REQ]) begin
          k = (m_ptr + off) % NUM_REQ;
          break;
        end
      end
    end
    exp_gnt = (k >= 0) ? (1 << k) : 0;
    chk("gnt", 32'(gnt), 32'(exp_gnt));
    chk("sum_valid", 32'(sum_valid), 32'(m_out_v));
    chk("sum_data", 32'(sum_data), 32'(m_out_data));
    chk("sum_carry", 32'(sum_carry), 32'(m_out_carry));
    chk("sum_id", 32'(sum_id), 32'(m_out_id));
    chk("busy", 32'(busy), 32'((m_s1_v || m_out_v) ? 1 : 0));
    if (!rst_a) begin
      m_ptr = 0; m_s1_v = 0; m_s1_a = 0; m_s1_b = 0; m_s1_id = 0;
      m_out_v = 0; m_out_data = 0; m_out_carry = 0; m_out_id = 0;
    end else if (adv) begin
      m_out_v = m_s1_v;
      if (m_s1_v) begin
        total       = m_s1_a + m_s1_b;
        m_out_data  = total % (1 << WIDTH);
        m_out_carry = total / (1 << WIDTH);
        m_out_id    = m_s1_id;
      end
      m_s1_v = (k >= 0) ? 1 : 0;
      if (k >= 0) begin
        m_s1_a  = int'(op_a[k*WIDTH +: WIDTH]);
        m_s1_b  = int'(op_b[k*WIDTH +: WIDTH]);
        m_s1_id = k;
        m_ptr   = (k + 1) % NUM_REQ;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    op_a = NUM_REQ*WIDTH'($urandom);
    op_b = NUM_REQ*WIDTH'($urandom);
  endtask

  initial begin
    rst_a = 1'b0; enable = 1'b1; req = '0; sum_ready = 1'b1;
    op_a = '0; op_b = '0;
    m_ptr = 0; m_s1_v = 0; m_s1_a = 0; m_s1_b = 0; m_s1_id = 0;
    m_out_v = 0; m_out_data = 0; m_out_carry = 0; m_out_id = 0;
    @(posedge clk);
    #1;
    repeat (2) step();
    rst_a = 1'b1;

    // Single request 3+4 from requester 0, then drain
    set_ops(0, 3, 4);
    req = 4'b0001;
    step();
    req = '0;
    repeat (4) step();

    // All requesters active: strict rotation, one result per cycle
    req = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      rand_ops();
      step();
    end
    req = '0;
    repeat (3) step();

    // Overflow cases
    set_ops(2, 31, 1);
    req = 4'b0100;
    step();
    set_ops(1, 20, 20);
    req = 4'b0010;
    step();
    req = '0;
    repeat (3) step();

    // Backpressure after the first result appears
    req = 4'b1111;
    rand_ops();
    repeat (3) step();
    sum_ready = 1'b0;
    repeat (6) step();
    sum_ready = 1'b1;
    repeat (4) step();

    // Enable low mid-stream
    enable = 1'b0;
    repeat (5) step();
    enable = 1'b1;
    repeat (4) step();

    // Reset with both stages full, then resume from requester 0
    rst_a = 1'b0;
    step();
    rst_a = 1'b1;
    repeat (5) step();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst_a     = ($urandom_range(99) < 2) ? 1'b0 : 1'b1;
      enable    = ($urandom_range(99) < 90) ? 1'b1 : 1'b0;
      sum_ready = ($urandom_range(99) < 75) ? 1'b1 : 1'b0;
      req       = NUM_REQ'($urandom);
      rand_ops();
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
